// File: rtl/data_sram_resp_pkg.sv
// Shared CPU bus definitions: data-bus width, byte-lane count and default
// data SRAM depth. These are used by the data SRAM response block.
package data_sram_resp_pkg;
   localparam int BUS_W      = 32;
   localparam int LANES      = 4;
   localparam int LANE_W     = BUS_W / LANES;
   localparam int DEF_ADDR_W = 12;
endpackage

// File: rtl/data_sram_resp_byte_lane.sv
// One 8-bit byte lane of the data SRAM: single-port array with a registered,
// read-first output that can be synchronously cleared.
module dram_byte_lane
   import data_sram_resp_pkg::*;
#(
   parameter int ADDR_W = DEF_ADDR_W
) (
   input  logic              clk,
   input  logic              clr_i,
   input  logic              rd_i,
   input  logic              we_i,
   input  logic [ADDR_W-1:0] addr_i,
   input  logic [LANE_W-1:0] wdata_i,
   output logic [LANE_W-1:0] rdata_o
);
   logic [LANE_W-1:0] mem_q [2**ADDR_W];
   logic [LANE_W-1:0] rdata_q;

   // Output register samples the array before the write lands (read-first).
   always_ff @(posedge clk) begin
      if (clr_i) begin
         rdata_q <= '0;
      end else if (rd_i) begin
         rdata_q <= mem_q[addr_i];
      end
      if (we_i) begin
         mem_q[addr_i] <= wdata_i;
      end
   end

   assign rdata_o = rdata_q;
endmodule

// File: rtl/data_sram_resp.sv
// Word-addressed data SRAM with byte write enables, one-cycle read latency,
// out-of-range detection and read/write access counters.
module data_sram_resp
   import data_sram_resp_pkg::*;
#(
   parameter int ADDR_W = DEF_ADDR_W,
   parameter int CNT_W  = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              data_sram_en,
   input  logic [LANES-1:0]  data_sram_wen,
   input  logic [BUS_W-1:0]  data_sram_addr,
   input  logic [BUS_W-1:0]  data_sram_wdata,
   output logic [BUS_W-1:0]  data_sram_rdata,
   output logic              addr_err,
   output logic [CNT_W-1:0]  rd_cnt,
   output logic [CNT_W-1:0]  wr_cnt
);
   logic              in_range;
   logic              accept;
   logic              is_write;
   logic              lane_clr;
   logic [ADDR_W-1:0] word_idx;
   logic              addr_lsb_unused;

   logic              addr_err_q, addr_err_d;
   logic [CNT_W-1:0]  rd_cnt_q, rd_cnt_d;
   logic [CNT_W-1:0]  wr_cnt_q, wr_cnt_d;

   assign in_range        = (data_sram_addr[BUS_W-1:ADDR_W+2] == '0);
   assign word_idx        = data_sram_addr[ADDR_W+1:2];
   assign addr_lsb_unused = ^data_sram_addr[1:0];
   assign accept          = data_sram_en & ~reset & in_range;
   assign is_write        = |data_sram_wen;
   // Out-of-range requests return zero rather than holding the old word.
   assign lane_clr        = reset | (data_sram_en & ~in_range);

   generate
      for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
         dram_byte_lane #(
            .ADDR_W (ADDR_W)
         ) u_lane (
            .clk     (clk),
            .clr_i   (lane_clr),
            .rd_i    (accept),
            .we_i    (accept & data_sram_wen[gi]),
            .addr_i  (word_idx),
            .wdata_i (data_sram_wdata[gi*LANE_W +: LANE_W]),
            .rdata_o (data_sram_rdata[gi*LANE_W +: LANE_W])
         );
      end
   endgenerate

   always_comb begin
      rd_cnt_d   = rd_cnt_q;
      wr_cnt_d   = wr_cnt_q;
      addr_err_d = data_sram_en & ~in_range;
      if (accept) begin
         if (is_write) begin
            wr_cnt_d = wr_cnt_q + CNT_W'(1);
         end else begin
            rd_cnt_d = rd_cnt_q + CNT_W'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         addr_err_q <= 1'b0;
         rd_cnt_q   <= '0;
         wr_cnt_q   <= '0;
      end else begin
         addr_err_q <= addr_err_d;
         rd_cnt_q   <= rd_cnt_d;
         wr_cnt_q   <= wr_cnt_d;
      end
   end

   assign addr_err = addr_err_q;
   assign rd_cnt   = rd_cnt_q;
   assign wr_cnt   = wr_cnt_q;
endmodule
